// File: rtl/csla_pipe_if.sv
// Operand/result handshake bundle for csla_pipe: producer side (in_*) and consumer side (out_*).
interface csla_pipe_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/csla_pipe.sv
// Elastic pipelined carry-select adder/subtractor; each stage resolves NB/STAGES blocks
// and forwards the still-unresolved upper operands plus the carry out of its last block.
module csla_pipe #(
    parameter int WIDTH  = 64,
    parameter int BLOCK  = 8,
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    csla_pipe_if.slave bus
);
    localparam int NB  = WIDTH / BLOCK;
    localparam int BPS = NB / STAGES;
    localparam int SW  = BPS * BLOCK;

    logic [STAGES-1:0] vld_q, vld_d, free, adv, ld;

    // Ready ripples back from the consumer; a stage is free if empty or draining this cycle.
    always_comb begin
        logic f, pv;
        adv   = '0;
        free  = '0;
        ld    = '0;
        vld_d = vld_q;
        f     = bus.out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s]  = vld_q[s] & f;
            free[s] = ~vld_q[s] | adv[s];
            f       = free[s];
        end
        pv = bus.in_valid;
        for (int s = 0; s < STAGES; s++) begin
            ld[s]    = pv & free[s];
            vld_d[s] = ld[s] | (vld_q[s] & ~adv[s]);
            pv       = vld_q[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    assign bus.in_ready  = free[0];
    assign bus.out_valid = vld_q[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = s * SW;
        localparam int OW = WIDTH - LO;

        logic [OW-1:0]    sa, sb;
        logic [WIDTH-1:0] ss, s_d, s_q;
        logic             sc, c_d, c_q;

        if (s == 0) begin : g_src
            assign sa = bus.a;
            assign sb = bus.sub ? ~bus.b : bus.b;
            assign sc = bus.sub ^ bus.cin;
            assign ss = '0;
        end else begin : g_src
            assign sa = g_stg[s-1].g_opq.a_q;
            assign sb = g_stg[s-1].g_opq.b_q;
            assign sc = g_stg[s-1].c_q;
            assign ss = g_stg[s-1].s_q;
        end

        always_comb begin
            logic             cy;
            logic [BLOCK:0]   r0, r1;
            s_d = ss;
            cy  = sc;
            r0  = '0;
            r1  = '0;
            for (int j = 0; j < BPS; j++) begin
                r0 = {1'b0, sa[j*BLOCK +: BLOCK]} + {1'b0, sb[j*BLOCK +: BLOCK]};
                r1 = {1'b0, sa[j*BLOCK +: BLOCK]} + {1'b0, sb[j*BLOCK +: BLOCK]}
                   + {{BLOCK{1'b0}}, 1'b1};
                s_d[LO + j*BLOCK +: BLOCK] = cy ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                cy = cy ? r1[BLOCK] : r0[BLOCK];
            end
            c_d = cy;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ld[s]) begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        if (s < STAGES - 1) begin : g_opq
            logic [OW-SW-1:0] a_q, b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld[s]) begin
                    a_q <= sa[OW-1:SW];
                    b_q <= sb[OW-1:SW];
                end
            end
        end else begin : g_out
            logic ovf_q;
            // carry into the MSB recovered from sum^a^b at that bit, XOR carry out
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        ovf_q <= 1'b0;
                else if (ld[s]) ovf_q <= s_d[WIDTH-1] ^ sa[OW-1] ^ sb[OW-1] ^ c_d;
            end
            assign bus.sum  = s_q;
            assign bus.cout = c_q;
            assign bus.ovf  = ovf_q;
        end
    end
endmodule
